pin_comparador_seq: RTL
=======================

Name: pin_comparador_seq

Overview:
- Sequential PIN verifier for the multibanco machine.
- Accepts keypad digits one per handshake, assembles a DIGITS-long PIN, compares it against the card code COD, and reports success or failure.
- Counts failed attempts and locks the card after MAX_TRIES failures.
- Sits between the keypad decoder and the transaction control FSM. Supersedes the plain combinational PIN/COD compare.

Parameters:
- DIGITS, 4, number of PIN digits (2..8)
- DIGIT_W, 4, bits per digit (BCD)
- MAX_TRIES, 3, failed attempts allowed before lock (1..15)
- LOCK_CYCLES, 1000, auto-unlock delay in clock cycles (used only with LOCK_TIMER_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- digit_valid  in  1  digit strobe, one digit per cycle high
- digit  in  DIGIT_W  keypad digit, legal 0..9
- clear  in  1  discard partial entry
- unlock  in  1  operator unlock of a locked card
- COD  in  DIGITS*DIGIT_W  stored card code, first digit in MSBs
- ok  out  1  one-cycle pulse: PIN matched
- fail  out  1  one-cycle pulse: PIN mismatched
- err  out  1  one-cycle pulse: illegal digit (>9) rejected
- locked  out  1  card locked
- tries_left  out  4  remaining attempts
- n_digits  out  4  digits entered so far

Behaviour:
- Clocking and reset:
  - One clock: clk.
  - Reset is synchronous and active-high: rst sampled on the rising edge of clk.
  - Reset values: state=ENTRY, pin register=0, n_digits=0, tries_left=MAX_TRIES, ok=fail=err=0, locked=0.
  - rst mid-entry or mid-CHECK aborts with no ok/fail pulse.
- States: ENTRY, CHECK, LOCKED.
- ENTRY:
  - digit_valid=1 with digit<=9: the digit shifts into the pin register (first digit lands in the MSBs); n_digits increments.
  - digit_valid=1 with digit>9: digit discarded, err pulses next cycle, n_digits unchanged.
  - When the accepted digit makes n_digits==DIGITS, go to CHECK.
  - clear=1: pin register and n_digits go to 0. clear has priority over a simultaneous digit_valid.
- CHECK (exactly 1 cycle):
  - Compares the full pin register with COD as sampled in this cycle.
  - ok/fail pulse on the edge leaving CHECK. Latency from the last digit edge to the result pulse is 2 edges.
  - digit_valid and clear are ignored during CHECK.
  - Match: ok=1, tries_left reloads to MAX_TRIES, n_digits=0, go to ENTRY.
  - Mismatch: fail=1, tries_left decrements, n_digits=0.
    - If tries_left was 1: go to LOCKED with tries_left=0 and locked=1, in the same edge as the fail pulse.
    - Otherwise: go to ENTRY.
- LOCKED:
  - digit_valid is ignored and raises no err; clear is ignored.
  - unlock=1: go to ENTRY, locked=0, tries_left=MAX_TRIES, n_digits=0.
  - unlock has no effect outside LOCKED.
- Output timing: ok, fail and err are registered and never high in the same cycle.

Optional Feature:
- Macro: LOCK_TIMER_EN.
- Defined:
  - A down-counter, width clog2(LOCK_CYCLES+1), loads LOCK_CYCLES on entry to LOCKED.
  - It decrements each cycle. Reaching 0 performs the same action as unlock.
  - unlock still works immediately. The counter resets to 0 on rst.
- Undefined:
  - No counter exists; LOCKED is left only through unlock or rst. LOCK_CYCLES is unused.

Test Plan:
- Correct PIN: COD=16'h1234, key 1,2,3,4 on consecutive cycles -> ok pulse 2 edges after the digit 4 edge; tries_left=3; n_digits=0.
- Wrong PIN to lock: COD=16'h1234, enter 1,2,3,5 three times -> fail pulses with tries_left 2, 1, 0; locked=1 after the third; further digits are ignored and n_digits stays 0.
- Illegal digit and clear: enter 1, 0xA, 2 -> err pulses once, n_digits=2; then clear together with digit_valid -> n_digits=0. Next, entering 1,2,3,4 gives ok.
- Recovery after fail: one wrong entry (tries_left=2) then the correct PIN -> ok; tries_left reloads to 3.
- Unlock: in LOCKED, assert unlock for 1 cycle -> locked=0, tries_left=3; correct PIN then gives ok. Asserting unlock in ENTRY changes nothing.
- Reset and timer: rst on the edge after the 3rd digit -> no ok/fail, n_digits=0. With LOCK_TIMER_EN and LOCK_CYCLES=8: after lock, locked falls exactly 8 cycles after rising.

Source files
------------

// File: rtl/pin_comparador_seq.sv
// pin_comparador_seq: sequential PIN verifier for the multibanco machine.
// Collects DIGITS keypad digits, one per digit_valid strobe, with the first
// digit landing in the MSBs. It compares the assembled PIN against the card
// code COD, pulses ok or fail, and counts the failed attempts. After
// MAX_TRIES failures the card is locked until the operator unlocks it.
//
// Optional build macro LOCK_TIMER_EN:
//   When defined, a down-counter releases a locked card LOCK_CYCLES clock
//   cycles after the lock. When undefined, only unlock or rst release a
//   locked card, and LOCK_CYCLES is ignored.
module pin_comparador_seq #(
    parameter int DIGITS      = 4,
    parameter int DIGIT_W     = 4,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      digit_valid,
    input  logic [DIGIT_W-1:0]        digit,
    input  logic                      clear,
    input  logic                      unlock,
    input  logic [DIGITS*DIGIT_W-1:0] COD,
    output logic                      ok,
    output logic                      fail,
    output logic                      err,
    output logic                      locked,
    output logic [3:0]                tries_left,
    output logic [3:0]                n_digits
);

    localparam int         PIN_W      = DIGITS * DIGIT_W;
    localparam logic [3:0] TRIES_INIT = 4'(MAX_TRIES);
    localparam logic [3:0] LAST_IDX   = 4'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_ENTRY  = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [PIN_W-1:0]   pin_reg, pin_nxt;
    logic [3:0]         n_digits_nxt;
    logic [3:0]         tries_nxt;
    logic               ok_nxt, fail_nxt, err_nxt, locked_nxt;

    // Decoded events for the current cycle
    logic               do_clear;
    logic               take_digit;
    logic               bad_digit;
    logic               last_digit;
    logic               pin_match;
    logic               last_try;
    logic               timer_expire;
    logic               lock_release;

    // A keypad digit is legal only in the BCD range 0..9
    function automatic logic digit_legal(input logic [DIGIT_W-1:0] d);
        return int'(d) <= 9;
    endfunction

    // Shift a new digit in at the LSB end; after DIGITS shifts the first
    // digit entered sits in the MSBs, matching the layout of COD
    function automatic logic [PIN_W-1:0] shift_in(input logic [PIN_W-1:0]   pin,
                                                  input logic [DIGIT_W-1:0] d);
        return {pin[PIN_W-DIGIT_W-1:0], d};
    endfunction

`ifdef LOCK_TIMER_EN
    localparam int            TMR_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCK_CYCLES);

    logic [TMR_W-1:0] lock_tmr, lock_tmr_nxt;

    // The release fires on the edge where the counter would reach zero, so
    // locked stays high for exactly LOCK_CYCLES cycles
    assign timer_expire = (state == ST_LOCKED) && (lock_tmr <= TMR_W'(1));
`else
    assign timer_expire = 1'b0;
`endif

    // Event decode: clear has priority over a digit strobe, and digits are
    // only considered while collecting a PIN
    always_comb begin
        do_clear     = (state == ST_ENTRY) && clear;
        take_digit   = (state == ST_ENTRY) && !clear && digit_valid && digit_legal(digit);
        bad_digit    = (state == ST_ENTRY) && !clear && digit_valid && !digit_legal(digit);
        last_digit   = take_digit && (n_digits == LAST_IDX);
        pin_match    = (pin_reg == COD);
        last_try     = (tries_left <= 4'd1);
        lock_release = (state == ST_LOCKED) && (unlock || timer_expire);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ENTRY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: CHECK always lasts a single cycle
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ENTRY: begin
                if (last_digit) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!pin_match && last_try) begin
                    state_nxt = ST_LOCKED;
                end else begin
                    state_nxt = ST_ENTRY;
                end
            end
            ST_LOCKED: begin
                if (lock_release) begin
                    state_nxt = ST_ENTRY;
                end
            end
            default: begin
                state_nxt = ST_ENTRY;
            end
        endcase
    end

    // Output and datapath decode: next values of the registered pulses,
    // the PIN shift register and the digit and attempt counters
    always_comb begin
        pin_nxt      = pin_reg;
        n_digits_nxt = n_digits;
        tries_nxt    = tries_left;
        locked_nxt   = locked;
        ok_nxt       = 1'b0;
        fail_nxt     = 1'b0;
        err_nxt      = 1'b0;
`ifdef LOCK_TIMER_EN
        lock_tmr_nxt = lock_tmr;
`endif
        case (state)
            ST_ENTRY: begin
                if (do_clear) begin
                    pin_nxt      = '0;
                    n_digits_nxt = 4'd0;
                end else if (take_digit) begin
                    pin_nxt      = shift_in(pin_reg, digit);
                    n_digits_nxt = n_digits + 4'd1;
                end else if (bad_digit) begin
                    err_nxt = 1'b1;
                end
            end
            ST_CHECK: begin
                pin_nxt      = '0;
                n_digits_nxt = 4'd0;
                if (pin_match) begin
                    ok_nxt    = 1'b1;
                    tries_nxt = TRIES_INIT;
                end else begin
                    fail_nxt = 1'b1;
                    if (last_try) begin
                        tries_nxt  = 4'd0;
                        locked_nxt = 1'b1;
`ifdef LOCK_TIMER_EN
                        lock_tmr_nxt = TMR_LOAD;
`endif
                    end else begin
                        tries_nxt = tries_left - 4'd1;
                    end
                end
            end
            ST_LOCKED: begin
                if (lock_release) begin
                    locked_nxt   = 1'b0;
                    tries_nxt    = TRIES_INIT;
                    n_digits_nxt = 4'd0;
                    pin_nxt      = '0;
`ifdef LOCK_TIMER_EN
                    lock_tmr_nxt = '0;
`endif
                end else begin
`ifdef LOCK_TIMER_EN
                    lock_tmr_nxt = lock_tmr - TMR_W'(1);
`endif
                end
            end
            default: begin
                pin_nxt      = '0;
                n_digits_nxt = 4'd0;
            end
        endcase
    end

    // Datapath and output registers; reset aborts any entry or pending check
    always_ff @(posedge clk) begin
        if (rst) begin
            pin_reg    <= '0;
            n_digits   <= 4'd0;
            tries_left <= TRIES_INIT;
            locked     <= 1'b0;
            ok         <= 1'b0;
            fail       <= 1'b0;
            err        <= 1'b0;
        end else begin
            pin_reg    <= pin_nxt;
            n_digits   <= n_digits_nxt;
            tries_left <= tries_nxt;
            locked     <= locked_nxt;
            ok         <= ok_nxt;
            fail       <= fail_nxt;
            err        <= err_nxt;
        end
    end

`ifdef LOCK_TIMER_EN
    // Auto-unlock counter, loaded when the card locks
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_tmr <= '0;
        end else begin
            lock_tmr <= lock_tmr_nxt;
        end
    end
`endif

endmodule
